uart_imem_loader: RTL and testbench

// - UART receiver plus word assembler that writes program words into instruction memory.
// - It is the write side of Instr_Mem, which the datapath only reads.
// - Sits in Mod_Teste with rx on UART_RXD. Bytes arrive LSB-first, 8N1.
// - Every 4 bytes form one little-endian 32-bit word, written at an auto-incremented word address.

---
 rtl/uart_imem_loader_if.sv | 24 ++
 rtl/uart_imem_loader.sv | 176 +++++++++++++++++
 tb/tb_uart_imem_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_if.sv
// Write-side bundle between the UART program loader and instruction memory.
// The loader (master) consumes rx/en and drives the memory write port and status.
interface uart_imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx;
   logic              en;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic [ADDR_W:0]   word_cnt;
   logic              full;
   logic              frame_err;

   modport master (
      input  rx, en,
      output we, waddr, wdata, word_cnt, full, frame_err
   );

   modport slave (
      output rx, en,
      input  we, waddr, wdata, word_cnt, full, frame_err
   );
endinterface

// File: rtl/uart_imem_loader.sv
// 8N1 UART receiver that packs every four bytes (little-endian) into a 32-bit
// word and writes it to instruction memory at an auto-incremented address.
module uart_imem_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   uart_imem_loader_if.master bus
);
   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam logic [TMR_W-1:0]  HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0]  BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t            state_reg, state_next;
   logic [TMR_W-1:0]  timer_reg, timer_next;
   logic [2:0]        bit_idx_reg, bit_idx_next;
   logic [7:0]        shift_reg, shift_next;
   logic              byte_ok;
   logic              stop_bad;

   logic              rx_meta_reg, rx_s_reg;
   logic [1:0]        byte_idx_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] waddr_reg;
   logic [31:0]       wdata_reg;
   logic [ADDR_W:0]   word_cnt_reg;
   logic [ADDR_W:0]   word_cnt_inc;
   logic              full_reg;
   logic              frame_err_reg;

   assign word_cnt_inc = word_cnt_reg + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_reg <= 1'b1;
         rx_s_reg    <= 1'b1;
      end else begin
         rx_meta_reg <= bus.rx;
         rx_s_reg    <= rx_meta_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         timer_reg   <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg + 1'b1;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      byte_ok      = 1'b0;
      stop_bad     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            timer_next = '0;
            if (!rx_s_reg && !full_reg) state_next = ST_START;
         end
         ST_START: begin
            if (timer_reg == HALF_LAST) begin
               timer_next = '0;
               if (!rx_s_reg) begin
                  state_next   = ST_DATA;
                  bit_idx_next = '0;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (timer_reg == BIT_LAST) begin
               timer_next              = '0;
               shift_next[bit_idx_reg] = rx_s_reg;
               if (bit_idx_reg == 3'd7) state_next = ST_STOP;
               else                     bit_idx_next = bit_idx_reg + 1'b1;
            end
         end
         ST_STOP: begin
            if (timer_reg == BIT_LAST) begin
               timer_next = '0;
               if (rx_s_reg) begin
                  byte_ok    = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  stop_bad   = 1'b1;
                  state_next = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // A held-low line (break) must release before a new start bit counts.
            timer_next = '0;
            if (rx_s_reg) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (!bus.en) begin
         state_next = ST_IDLE;
         timer_next = '0;
         byte_ok    = 1'b0;
         stop_bad   = 1'b0;
      end
   end

   // Lanes 0..2 hold the first three bytes; byte 3 comes straight from shift_reg.
   for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            lane_reg <= '0;
         end else if (byte_ok && byte_idx_reg == 2'(gi)) begin
            lane_reg <= shift_reg;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx_reg  <= '0;
         we_reg        <= 1'b0;
         waddr_reg     <= '0;
         wdata_reg     <= '0;
         word_cnt_reg  <= '0;
         full_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
      end else if (!bus.en) begin
         byte_idx_reg  <= '0;
         we_reg        <= 1'b0;
         word_cnt_reg  <= '0;
         full_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         we_reg <= 1'b0;
         if (stop_bad) frame_err_reg <= 1'b1;
         if (byte_ok) begin
            byte_idx_reg <= byte_idx_reg + 1'b1;
            if (byte_idx_reg == 2'd3) begin
               we_reg       <= 1'b1;
               waddr_reg    <= word_cnt_reg[ADDR_W-1:0];
               wdata_reg    <= {shift_reg, g_lane[2].lane_reg,
                                g_lane[1].lane_reg, g_lane[0].lane_reg};
               word_cnt_reg <= word_cnt_inc;
               full_reg     <= (word_cnt_inc == DEPTH);
            end
         end
      end
   end

   // Gating with en makes an en drop during the strobe cycle suppress the write.
   assign bus.we        = we_reg & bus.en;
   assign bus.waddr     = waddr_reg;
   assign bus.wdata     = wdata_reg;
   assign bus.word_cnt  = word_cnt_reg;
   assign bus.full      = full_reg;
   assign bus.frame_err = frame_err_reg;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: expected writes are queued as bytes are
// sent and matched against every observed write strobe.
module tb_uart_imem_loader;
   localparam int CPB    = 8;
   localparam int ADDR_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails  = 0;
   int   we_seen = 0;
   logic [ADDR_W+31:0] sb_q[$];

   always #5 clk = ~clk;

   uart_imem_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

   uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always @(negedge clk) begin
      if (bus_if.we) begin
         logic [ADDR_W+31:0] exp_w;
         we_seen++;
         checks++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_we: got waddr=%0d wdata=%h, expected no write",
                     bus_if.waddr, bus_if.wdata);
         end else begin
            exp_w = sb_q.pop_front();
            if ({bus_if.waddr, bus_if.wdata} !== exp_w) begin
               fails++;
               $display("FAIL write: got waddr=%0d wdata=%h, expected waddr=%0d wdata=%h",
                        bus_if.waddr, bus_if.wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
            end else begin
               $display("write ok: waddr=%0d wdata=%h", bus_if.waddr, bus_if.wdata);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
      bus_if.rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         bus_if.rx = b[i];
         tick(CPB);
      end
      bus_if.rx = stop_ok;
      tick(CPB);
      bus_if.rx = 1'b1;
      tick(4);
      $display("sent byte %h stop=%0b", b, stop_ok);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      sb_q.push_back({a, d});
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick();
      checks++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout: %0d writes still pending, expected 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic clear_loader();
      bus_if.en = 1'b0;
      tick(2);
      bus_if.en = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      checks++;
      if ({bus_if.we, bus_if.waddr, bus_if.wdata, bus_if.word_cnt, bus_if.full, bus_if.frame_err} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: we=%b waddr=%0d wdata=%h cnt=%0d full=%b ferr=%b, expected all 0",
                  bus_if.we, bus_if.waddr, bus_if.wdata, bus_if.word_cnt, bus_if.full, bus_if.frame_err);
      end
      rst = 1'b0;
      tick(3);
      bus_if.en = 1'b1;
      tick();
      checks++;
      if (bus_if.word_cnt !== 3'd0 || bus_if.we !== 1'b0) begin
         fails++;
         $display("FAIL post_reset: cnt=%0d we=%b, expected 0 0", bus_if.word_cnt, bus_if.we);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_word();
      push_exp(2'd0, 32'h00500013);
      send_word(32'h00500013);
      wait_drain("single_word");
      checks++;
      if (bus_if.word_cnt !== 3'd1 || bus_if.frame_err !== 1'b0) begin
         fails++;
         $display("FAIL single_word_status: cnt=%0d ferr=%b, expected 1 0", bus_if.word_cnt, bus_if.frame_err);
      end
      $display("test_single_word done");
   endtask

   task automatic test_glitch();
      int seen0;
      clear_loader();
      seen0 = we_seen;
      bus_if.rx = 1'b0;
      tick(2);
      bus_if.rx = 1'b1;
      tick(3 * CPB);
      checks++;
      if (we_seen != seen0 || bus_if.word_cnt !== 3'd0 || bus_if.frame_err !== 1'b0) begin
         fails++;
         $display("FAIL glitch: writes=%0d cnt=%0d ferr=%b, expected 0 0 0",
                  we_seen - seen0, bus_if.word_cnt, bus_if.frame_err);
      end
      push_exp(2'd0, 32'h89ABCDEF);
      send_word(32'h89ABCDEF);
      wait_drain("glitch_word");
      $display("test_glitch done");
   endtask

   task automatic test_frame_err();
      clear_loader();
      send_byte(8'hF0, 1'b0);
      checks++;
      if (bus_if.frame_err !== 1'b1 || bus_if.word_cnt !== 3'd0) begin
         fails++;
         $display("FAIL frame_err_set: ferr=%b cnt=%0d, expected 1 0", bus_if.frame_err, bus_if.word_cnt);
      end
      push_exp(2'd0, 32'h04030201);
      send_word(32'h04030201);
      wait_drain("frame_err_word");
      checks++;
      if (bus_if.frame_err !== 1'b1 || bus_if.word_cnt !== 3'd1) begin
         fails++;
         $display("FAIL frame_err_sticky: ferr=%b cnt=%0d, expected 1 1", bus_if.frame_err, bus_if.word_cnt);
      end
      $display("test_frame_err done");
   endtask

   task automatic test_full();
      int seen0;
      clear_loader();
      for (int w = 0; w < 4; w++) begin
         push_exp(2'(w), 32'hC0DE0000 + 32'(w) * 32'h0101);
         send_word(32'hC0DE0000 + 32'(w) * 32'h0101);
      end
      wait_drain("full_words");
      checks++;
      if (bus_if.full !== 1'b1 || bus_if.word_cnt !== 3'd4) begin
         fails++;
         $display("FAIL full_status: full=%b cnt=%0d, expected 1 4", bus_if.full, bus_if.word_cnt);
      end
      seen0 = we_seen;
      send_word(32'h5555AAAA);
      tick(20);
      checks++;
      if (we_seen != seen0 || bus_if.word_cnt !== 3'd4 || bus_if.full !== 1'b1) begin
         fails++;
         $display("FAIL full_ignore: writes=%0d cnt=%0d full=%b, expected 0 4 1",
                  we_seen - seen0, bus_if.word_cnt, bus_if.full);
      end
      $display("test_full done");
   endtask

   task automatic test_en_abort();
      clear_loader();
      send_byte(8'h11);
      send_byte(8'h22);
      bus_if.en = 1'b0;
      tick();
      bus_if.en = 1'b1;
      tick();
      checks++;
      if (bus_if.full !== 1'b0 || bus_if.word_cnt !== 3'd0) begin
         fails++;
         $display("FAIL en_clear: full=%b cnt=%0d, expected 0 0", bus_if.full, bus_if.word_cnt);
      end
      push_exp(2'd0, 32'hDDCCBBAA);
      send_word(32'hDDCCBBAA);
      wait_drain("en_abort_word");
      $display("test_en_abort done");
   endtask

   task automatic test_reset_mid_frame();
      int seen0;
      clear_loader();
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      seen0 = we_seen;
      fork
         send_byte(8'h44);
         begin
            tick(CPB + 3 * CPB);
            rst = 1'b1;
            #1;
            checks++;
            if ({bus_if.we, bus_if.waddr, bus_if.wdata, bus_if.word_cnt, bus_if.full, bus_if.frame_err} !== '0) begin
               fails++;
               $display("FAIL reset_mid_frame: we=%b waddr=%0d wdata=%h cnt=%0d, expected all 0",
                        bus_if.we, bus_if.waddr, bus_if.wdata, bus_if.word_cnt);
            end
            tick();
            rst = 1'b0;
         end
      join
      tick(3 * CPB);
      checks++;
      if (we_seen != seen0 || bus_if.word_cnt !== 3'd0) begin
         fails++;
         $display("FAIL reset_no_write: writes=%0d cnt=%0d, expected 0 0", we_seen - seen0, bus_if.word_cnt);
      end
      $display("test_reset_mid_frame done");
   endtask

   initial begin
      bus_if.rx = 1'b1;
      bus_if.en = 1'b0;
      tick(3);
      test_reset();
      test_single_word();
      test_glitch();
      test_frame_err();
      test_full();
      test_en_abort();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
